s2p_rx: RTL and testbench

//   Serial-to-parallel receiver, far end of the p2s serial link. Samples the
//   LSB-first bit stream (data qualified by vld), assembles WIDTH-bit words and

---
 rtl/s2p_rx.sv | 120 ++++++++++++
 tb/tb_s2p_rx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/s2p_rx.sv
// Serial-to-parallel receiver: assembles LSB-first serial bits into WIDTH-bit
// words, queues them in a small FIFO read over valid/ready, and flags errors.
module s2p_rx #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 2,
  parameter int GAP_MAX = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       data,
  input  logic                       vld,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_vld,
  input  logic                       dout_rdy,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       ovf,
  output logic                       frag_err,
  input  logic                       clr_err
);
  localparam int CW = $clog2(WIDTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH+1);
  localparam int GW = (GAP_MAX > 0) ? $clog2(GAP_MAX+1) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH-1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_MAX > 0) ? GAP_MAX-1 : 0);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH-1);
  localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);

  // Handshake: a word leaves the FIFO on any edge where dout_vld=1 and
  // dout_rdy=1; dout is held stable while dout_vld=1 and dout_rdy=0.
  logic [WIDTH-1:0] sr_q, sr_d, assembled;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             ovf_q, ovf_d, frag_q, frag_d;
  logic             push, timeout, pop, full, accept, ovf_set;

  assign assembled = {data, sr_q[WIDTH-1:1]};
  assign pop       = (count_q != '0) && dout_rdy;
  assign full      = (count_q == OCC_FULL);
  assign accept    = push && (!full || pop);
  assign ovf_set   = push && full && !pop;

  always_comb begin
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    gap_d     = gap_q;
    push      = 1'b0;
    timeout   = 1'b0;
    if (vld) begin
      sr_d  = assembled;
      gap_d = '0;
      if (bit_cnt_q == BIT_LAST) begin
        bit_cnt_d = '0;
        push      = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
    end else if (bit_cnt_q != '0) begin
      // The edge on which the gap count would reach GAP_MAX discards the word.
      if ((GAP_MAX > 0) && (gap_q == GAP_LAST)) begin
        bit_cnt_d = '0;
        gap_d     = '0;
        timeout   = 1'b1;
      end else begin
        gap_d = gap_q + GW'(1);
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    if (pop)    rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    if (accept && !pop)      count_d = count_q + OW'(1);
    else if (!accept && pop) count_d = count_q - OW'(1);
    ovf_d  = ovf_set ? 1'b1 : (clr_err ? 1'b0 : ovf_q);
    frag_d = timeout ? 1'b1 : (clr_err ? 1'b0 : frag_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
      gap_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      frag_q    <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      gap_q     <= gap_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      frag_q    <= frag_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (accept) begin
      mem_q[wr_ptr_q] <= assembled;
    end
  end

  assign dout_vld = (count_q != '0);
  assign dout     = dout_vld ? mem_q[rd_ptr_q] : '0;
  assign bit_cnt  = bit_cnt_q;
  assign ovf      = ovf_q;
  assign frag_err = frag_q;
endmodule

// File: tb/tb_s2p_rx.sv
// Directed bench for s2p_rx: expected words go into a queue at stimulus time
// and a negedge monitor pops and compares them on every accepted output.
module tb_s2p_rx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data = 1'b0;
  logic       vld = 1'b0;
  logic [3:0] dout;
  logic       dout_vld;
  logic       dout_rdy = 1'b0;
  logic [2:0] bit_cnt;
  logic       ovf;
  logic       frag_err;
  logic       clr_err = 1'b0;

  logic [3:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  s2p_rx #(.WIDTH(4), .DEPTH(2), .GAP_MAX(8)) dut (
    .clk(clk), .rst(rst), .data(data), .vld(vld),
    .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
    .bit_cnt(bit_cnt), .ovf(ovf), .frag_err(frag_err), .clr_err(clr_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks: each returns 1ns after a rising edge
  task automatic drive_bit(input logic b);
    vld  = 1'b1;
    data = b;
    @(posedge clk); #1;
    vld  = 1'b0;
    data = 1'b0;
  endtask

  task automatic idle(input int n);
    vld = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_word(input logic [3:0] w, input logic rdy_on_last);
    for (int i = 0; i < 3; i++) drive_bit(w[i]);
    if (rdy_on_last) dout_rdy = 1'b1;
    drive_bit(w[3]);
    if (rdy_on_last) dout_rdy = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst && dout_vld && dout_rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", 32'(dout), 32'hFFFF_FFFF);
      end else begin
        check("pop_word", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_dout_vld", 32'(dout_vld), 0);
    check("rst_bit_cnt", 32'(bit_cnt), 0);
    check("rst_ovf", 32'(ovf), 0);

    // 1: single word 1,1,0,1 -> B, valid for one cycle
    dout_rdy = 1'b1;
    exp_q.push_back(4'hB);
    drive_bit(1); drive_bit(1); drive_bit(0);
    check("t1_no_vld_before_last", 32'(dout_vld), 0);
    drive_bit(1);
    check("t1_vld", 32'(dout_vld), 1);
    check("t1_dout", 32'(dout), 32'hB);
    idle(1);
    check("t1_vld_one_cycle", 32'(dout_vld), 0);

    // 2: short gap holds partial word
    exp_q.push_back(4'h6);
    drive_bit(0); drive_bit(1);
    check("t2_bit_cnt", 32'(bit_cnt), 2);
    idle(3);
    check("t2_bit_cnt_gap", 32'(bit_cnt), 2);
    check("t2_frag", 32'(frag_err), 0);
    drive_bit(1); drive_bit(0);
    check("t2_vld", 32'(dout_vld), 1);
    idle(2);

    // 3: gap of GAP_MAX discards partial word
    drive_bit(1); drive_bit(1);
    idle(7);
    check("t3_frag_before", 32'(frag_err), 0);
    check("t3_bit_cnt_before", 32'(bit_cnt), 2);
    idle(1);
    check("t3_frag", 32'(frag_err), 1);
    check("t3_bit_cnt", 32'(bit_cnt), 0);
    exp_q.push_back(4'h8);
    drive_bit(0); drive_bit(0); drive_bit(0); drive_bit(1);
    check("t3_frag_sticky", 32'(frag_err), 1);
    idle(2);
    pulse_clr();
    check("t3_frag_clr", 32'(frag_err), 0);

    // 4: overflow with consumer stalled
    dout_rdy = 1'b0;
    exp_q.push_back(4'h3);
    exp_q.push_back(4'h5);
    send_word(4'h3, 0);
    send_word(4'h5, 0);
    check("t4_no_ovf", 32'(ovf), 0);
    send_word(4'h9, 0);
    check("t4_ovf", 32'(ovf), 1);
    check("t4_head", 32'(dout), 32'h3);
    idle(2);
    check("t4_head_stable", 32'(dout), 32'h3);
    dout_rdy = 1'b1;
    idle(2);
    check("t4_empty", 32'(dout_vld), 0);
    pulse_clr();
    check("t4_ovf_clr", 32'(ovf), 0);

    // 5: push to a full FIFO with simultaneous pop is accepted
    dout_rdy = 1'b0;
    exp_q.push_back(4'hA);
    exp_q.push_back(4'hC);
    exp_q.push_back(4'hE);
    send_word(4'hA, 0);
    send_word(4'hC, 0);
    send_word(4'hE, 1);
    check("t5_ovf", 32'(ovf), 0);
    check("t5_head", 32'(dout), 32'hC);
    dout_rdy = 1'b1;
    idle(2);
    check("t5_empty", 32'(dout_vld), 0);

    // 6: asynchronous reset mid-word with a queued word
    dout_rdy = 1'b0;
    exp_q.push_back(4'h7);
    send_word(4'h7, 0);
    drive_bit(1); drive_bit(1);
    check("t6_bit_cnt_pre", 32'(bit_cnt), 2);
    rst = 1'b1;
    #2;
    exp_q.delete();
    check("t6_dout_vld", 32'(dout_vld), 0);
    check("t6_dout", 32'(dout), 0);
    check("t6_bit_cnt", 32'(bit_cnt), 0);
    check("t6_ovf", 32'(ovf), 0);
    check("t6_frag", 32'(frag_err), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    dout_rdy = 1'b1;
    exp_q.push_back(4'h5);
    drive_bit(1); drive_bit(0); drive_bit(1); drive_bit(0);
    check("t6_dout_after", 32'(dout), 32'h5);
    idle(3);

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
